leds: RTL and testbench



---
 rtl/leds_pkg.sv | 22 ++
 rtl/leds_blink_timer.sv | 33 +++
 rtl/leds.sv | 67 ++++++
 tb/tb_leds.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared types and constants for the user-LED driver.
// Pattern gating lives here so that the LED mapping and its gating rule stay in one place.
package leds_pkg;

    localparam int unsigned LED_N = 8;

    typedef logic [LED_N-1:0] led_vec_t;

    localparam led_vec_t LED_OFF = 8'h00;

    // Lit phase shows the pattern; the dark phase forces every LED off.
    function automatic led_vec_t led_gate(input logic lit, input led_vec_t pattern);
        led_vec_t res;
        if (lit) begin
            res = pattern;
        end else begin
            res = LED_OFF;
        end
        return res;
    endfunction

endpackage

// File: rtl/leds_blink_timer.sv
// Modulo-DIV cycle counter for the LED blinker.
// tick is high for exactly the one cycle in which the counter sits at its last value.
module blink_timer
    import leds_pkg::*;
#(
    parameter int unsigned DIV   = 1,
    parameter int unsigned CNT_W = 24
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt = '0;

    // tick decodes the registered count so the caller can act on the very edge that wraps it.
    assign tick = (cnt == CNT_LAST);

    // Counter advances every cycle and wraps exactly at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/leds.sv
// Board-level driver for the eight user LEDs D2..D9 of the iCE40-HX8K board.
// Shows PATTERN after reset, optionally blinking it on/off every BLINK_DIV clocks.
module leds
    import leds_pkg::*;
#(
    parameter led_vec_t    PATTERN   = 8'hFF,
    parameter int unsigned BLINK_DIV = 0,
    parameter int unsigned CNT_W     = 24
) (
    input  logic clk,
    input  logic rst,
    output logic D2,
    output logic D3,
    output logic D4,
    output logic D5,
    output logic D6,
    output logic D7,
    output logic D8,
    output logic D9
);

    // Initialised flops give defined LEDs before the first reset (supported on iCE40).
    led_vec_t led_q = LED_OFF;
    logic     phase = 1'b1;
    logic     tick;

    generate
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
            $error("leds: CNT_W must be in 1..32");
        end
        if ((64'(BLINK_DIV) >> CNT_W) != 64'd0) begin : g_bad_div
            $error("leds: BLINK_DIV does not fit in CNT_W bits");
        end

        if (BLINK_DIV > 0) begin : g_blink
            blink_timer #(
                .DIV   (BLINK_DIV),
                .CNT_W (CNT_W)
            ) u_blink_timer (
                .clk  (clk),
                .rst  (rst),
                .tick (tick)
            );
        end else begin : g_static
            // Without a timer the phase never flips, leaving the pattern permanently lit.
            assign tick = 1'b0;
        end
    endgenerate

    // Phase flips on each timer wrap; the LED register follows it one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b1;
            led_q <= LED_OFF;
        end else begin
            if (tick) begin
                phase <= ~phase;
            end else begin
                phase <= phase;
            end
            led_q <= led_gate(phase, PATTERN);
        end
    end

    assign {D9, D8, D7, D6, D5, D4, D3, D2} = led_q;

endmodule

// File: tb/tb_leds.sv
// Self-checking bench for leds: five parameterisations share one clock and reset,
// checked first against a fixed vector table, then against a reference model under random resets.
`timescale 1ns/1ps
module tb_leds;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wire [7:0] out_ff;
    wire [7:0] out_a5;
    wire [7:0] out_b3;
    wire [7:0] out_b1;
    wire [7:0] out_b5;

    leds #(.PATTERN(8'hFF), .BLINK_DIV(0)) u_ff (
        .clk(clk), .rst(rst),
        .D2(out_ff[0]), .D3(out_ff[1]), .D4(out_ff[2]), .D5(out_ff[3]),
        .D6(out_ff[4]), .D7(out_ff[5]), .D8(out_ff[6]), .D9(out_ff[7])
    );

    leds #(.PATTERN(8'hA5), .BLINK_DIV(0)) u_a5 (
        .clk(clk), .rst(rst),
        .D2(out_a5[0]), .D3(out_a5[1]), .D4(out_a5[2]), .D5(out_a5[3]),
        .D6(out_a5[4]), .D7(out_a5[5]), .D8(out_a5[6]), .D9(out_a5[7])
    );

    leds #(.PATTERN(8'hFF), .BLINK_DIV(3)) u_b3 (
        .clk(clk), .rst(rst),
        .D2(out_b3[0]), .D3(out_b3[1]), .D4(out_b3[2]), .D5(out_b3[3]),
        .D6(out_b3[4]), .D7(out_b3[5]), .D8(out_b3[6]), .D9(out_b3[7])
    );

    leds #(.PATTERN(8'h3C), .BLINK_DIV(1)) u_b1 (
        .clk(clk), .rst(rst),
        .D2(out_b1[0]), .D3(out_b1[1]), .D4(out_b1[2]), .D5(out_b1[3]),
        .D6(out_b1[4]), .D7(out_b1[5]), .D8(out_b1[6]), .D9(out_b1[7])
    );

    leds #(.PATTERN(8'h81), .BLINK_DIV(5), .CNT_W(3)) u_b5 (
        .clk(clk), .rst(rst),
        .D2(out_b5[0]), .D3(out_b5[1]), .D4(out_b5[2]), .D5(out_b5[3]),
        .D6(out_b5[4]), .D7(out_b5[5]), .D8(out_b5[6]), .D9(out_b5[7])
    );

    typedef struct {
        logic       rst;
        logic [7:0] ff;
        logic [7:0] a5;
        logic [7:0] b3;
        logic [7:0] b1;
        logic [7:0] b5;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;   // edges since the last reset edge

    function automatic vec_t mk(input logic r, input logic [7:0] ff, input logic [7:0] a5,
                                input logic [7:0] b3, input logic [7:0] b1, input logic [7:0] b5);
        vec_t v;
        v.rst = r; v.ff = ff; v.a5 = a5; v.b3 = b3; v.b1 = b1; v.b5 = b5;
        return v;
    endfunction

    // Reference rule: lit during the first DIV edges after reset, dark the next DIV, and so on.
    function automatic logic [7:0] model(input logic [7:0] pat, input int div, input int kk);
        if (kk == 0) return 8'h00;
        if (div == 0) return pat;
        return ((((kk - 1) / div) % 2) == 0) ? pat : 8'h00;
    endfunction

    function automatic logic [7:0] act_of(input int idx);
        case (idx)
            0:       return out_ff;
            1:       return out_a5;
            2:       return out_b3;
            3:       return out_b1;
            default: return out_b5;
        endcase
    endfunction

    function automatic logic [7:0] exp_of(input int idx, input int kk);
        case (idx)
            0:       return model(8'hFF, 0, kk);
            1:       return model(8'hA5, 0, kk);
            2:       return model(8'hFF, 3, kk);
            3:       return model(8'h3C, 1, kk);
            default: return model(8'h81, 5, kk);
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // Fixed table: 3 reset cycles, 12 run cycles, a one-cycle reset, 7 run cycles.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h81)); // k1
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h81)); // k2
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h81)); // k3
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h81)); // k4
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h3C, 8'h81)); // k5
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00)); // k6
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h00)); // k7
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h00)); // k8
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h00)); // k9
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00)); // k10
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h3C, 8'h81)); // k11
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h81)); // k12
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)); // mid-run reset
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h81)); // k1
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h81)); // k2
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h81)); // k3
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h81)); // k4
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h3C, 8'h81)); // k5
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00)); // k6
        tbl.push_back(mk(1'b0, 8'hFF, 8'hA5, 8'hFF, 8'h3C, 8'h00)); // k7

        // Power-up value before any clock edge.
        #1;
        for (int d = 0; d < 5; d++) check($sformatf("powerup[%0d]", d), act_of(d), 8'h00);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            @(posedge clk);
            #2;
            check($sformatf("tbl[%0d].ff", i), out_ff, tbl[i].ff);
            check($sformatf("tbl[%0d].a5", i), out_a5, tbl[i].a5);
            check($sformatf("tbl[%0d].b3", i), out_b3, tbl[i].b3);
            check($sformatf("tbl[%0d].b1", i), out_b1, tbl[i].b1);
            check($sformatf("tbl[%0d].b5", i), out_b5, tbl[i].b5);
            @(negedge clk);
        end
        k = 7;

        // Random resets against the reference model.
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 24) == 0);
            @(posedge clk);
            if (rst) k = 0;
            else     k = k + 1;
            #2;
            for (int d = 0; d < 5; d++)
                check($sformatf("rand[%0d].dut%0d k=%0d", c, d, k), act_of(d), exp_of(d, k));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
